// File: rtl/md_pkg.sv
// -----------------------------------------------------------------------------
// md_pkg -- shared definitions for the multiply/divide unit.
//   md_op_e    : operation encodings carried on the op field.
//   md_state_e : sequencer states (IDLE, MUL, DIV).
//   MD_DIV0_LO : default LO value loaded on a divide by zero.
// -----------------------------------------------------------------------------
package md_pkg;

  localparam int          MD_WIDTH   = 32;
  localparam logic [31:0] MD_DIV0_LO = 32'hFFFF_FFFF;

  // op[1] selects divide, op[0] selects unsigned.
  typedef enum logic [1:0] {
    MD_MULT  = 2'b00,
    MD_MULTU = 2'b01,
    MD_DIV   = 2'b10,
    MD_DIVU  = 2'b11
  } md_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2
  } md_state_e;

endpackage

// File: rtl/mul_div_unit_if.sv
// -----------------------------------------------------------------------------
// mul_div_unit_if -- request/result bundle between the control path and the
// multiply/divide unit.
//   master (control path) drives : start, op, src_a, src_b, hi_we, lo_we, wdata
//   slave  (mul_div_unit) drives : busy, done, hi, lo
// -----------------------------------------------------------------------------
interface mul_div_unit_if
  import md_pkg::*;
#(
  parameter int WIDTH = MD_WIDTH
);
  logic             start;
  md_op_e           op;
  logic [WIDTH-1:0] src_a;
  logic [WIDTH-1:0] src_b;
  logic             hi_we;
  logic             lo_we;
  logic [WIDTH-1:0] wdata;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, src_a, src_b, hi_we, lo_we, wdata,
    input  busy, done, hi, lo
  );

  modport slave (
    input  start, op, src_a, src_b, hi_we, lo_we, wdata,
    output busy, done, hi, lo
  );
endinterface

// File: rtl/md_divider_step.sv
// -----------------------------------------------------------------------------
// md_divider_step -- one combinational restoring-division step.
//   i_rem     : current partial remainder (always < divisor for divisor != 0)
//   i_msb     : next dividend bit shifted into the remainder
//   i_divisor : divisor magnitude
//   o_rem     : next partial remainder
//   o_qbit    : quotient bit produced by this step
// -----------------------------------------------------------------------------
module md_divider_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] i_rem,
  input  logic             i_msb,
  input  logic [WIDTH-1:0] i_divisor,
  output logic [WIDTH-1:0] o_rem,
  output logic             o_qbit
);
  logic [WIDTH:0]   w_shift;
  logic [WIDTH-1:0] w_diff;

  assign w_shift = {i_rem, i_msb};
  assign o_qbit  = (w_shift >= {1'b0, i_divisor});
  // When the subtraction is taken the true difference is below the divisor,
  // so the low WIDTH bits of the modular difference are exact.
  assign w_diff  = w_shift[WIDTH-1:0] - i_divisor;
  assign o_rem   = o_qbit ? w_diff : w_shift[WIDTH-1:0];
endmodule

// File: rtl/mul_div_unit.sv
// -----------------------------------------------------------------------------
// mul_div_unit -- iterative HI/LO multiply/divide unit (MULT, MULTU, DIV, DIVU,
// plus MTHI/MTLO writes). One result bit per cycle; busy stays high for WIDTH
// cycles after start and done pulses once when HI/LO are loaded.
//   clk  : clock, rising edge
//   rst  : synchronous active-high reset; aborts any operation in flight
//   bus  : mul_div_unit_if.slave (start/op/src_a/src_b/hi_we/lo_we/wdata in,
//          busy/done/hi/lo out)
// Build option: MD_FAST_MUL_EN -- multiplies complete with one registered
// full-width multiply (busy for one cycle); divide is unaffected.
// -----------------------------------------------------------------------------
module mul_div_unit
  import md_pkg::*;
#(
  parameter int               WIDTH   = MD_WIDTH,
  parameter logic [WIDTH-1:0] DIV0_LO = WIDTH'(MD_DIV0_LO)
) (
  input  logic           clk,
  input  logic           rst,
  mul_div_unit_if.slave  bus
);
  localparam int CW = $clog2(WIDTH);

  md_state_e          r_state, w_state_nxt;
  logic [CW-1:0]      r_count;
  logic [WIDTH-1:0]   r_a, r_b, r_hi, r_lo;
  logic [2*WIDTH-1:0] r_p;          // MUL: {acc_hi, multiplier/acc_lo}; DIV: {rem, dividend/quotient}
  logic               r_neg_q;      // product / quotient is negative
  logic               r_neg_r;      // remainder takes the dividend sign
  logic               r_done;

  logic               w_is_signed, w_sign_a, w_sign_b;
  logic [WIDTH-1:0]   w_mag_a, w_mag_b;
  logic               w_last, w_mul_last;
  logic [2*WIDTH-1:0] w_prod, w_prod_fix, w_div_next;
  logic [WIDTH-1:0]   w_rem_next, w_q_fix, w_r_fix;
  logic               w_qbit;

  assign w_is_signed = ~bus.op[0];
  assign w_sign_a    = w_is_signed & bus.src_a[WIDTH-1];
  assign w_sign_b    = w_is_signed & bus.src_b[WIDTH-1];
  assign w_mag_a     = w_sign_a ? -bus.src_a : bus.src_a;
  assign w_mag_b     = w_sign_b ? -bus.src_b : bus.src_b;
  assign w_last      = (r_count == CW'(WIDTH - 1));

`ifdef MD_FAST_MUL_EN
  assign w_mul_last = 1'b1;
  assign w_prod     = r_a * r_b;
`else
  logic [WIDTH:0] w_mul_sum;
  // Shift-add: add the multiplicand into the upper half when the current
  // multiplier bit is set, then shift the whole accumulator right one place.
  assign w_mul_sum  = {1'b0, r_p[2*WIDTH-1:WIDTH]} + (r_p[0] ? {1'b0, r_a} : '0);
  assign w_prod     = {w_mul_sum, r_p[WIDTH-1:1]};
  assign w_mul_last = w_last;
`endif
  assign w_prod_fix = r_neg_q ? -w_prod : w_prod;

  md_divider_step #(.WIDTH(WIDTH)) u_div_step (
    .i_rem     (r_p[2*WIDTH-1:WIDTH]),
    .i_msb     (r_p[WIDTH-1]),
    .i_divisor (r_b),
    .o_rem     (w_rem_next),
    .o_qbit    (w_qbit)
  );
  assign w_div_next = {w_rem_next, r_p[WIDTH-2:0], w_qbit};
  assign w_q_fix    = r_neg_q ? -w_div_next[WIDTH-1:0] : w_div_next[WIDTH-1:0];
  assign w_r_fix    = r_neg_r ? -w_rem_next : w_rem_next;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  // NOTE: the default assignment first guarantees every path drives the
  // signal, so no latch is inferred.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE:    if (bus.start) w_state_nxt = bus.op[1] ? DIV : MUL;
      MUL:     if (w_mul_last) w_state_nxt = IDLE;
      DIV:     if (w_last) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_p     <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (bus.start) begin
            // Start wins over a coincident MTHI/MTLO write.
            r_a     <= w_mag_a;
            r_b     <= w_mag_b;
            r_p     <= {{WIDTH{1'b0}}, (bus.op[1] ? w_mag_a : w_mag_b)};
            r_neg_q <= w_sign_a ^ w_sign_b;
            r_neg_r <= w_sign_a;
            r_count <= '0;
          end else begin
            if (bus.hi_we) r_hi <= bus.wdata;
            if (bus.lo_we) r_lo <= bus.wdata;
          end
        end
        MUL: begin
          r_p     <= w_prod;
          r_count <= r_count + 1'b1;
          if (w_mul_last) begin
            {r_hi, r_lo} <= w_prod_fix;
            r_done       <= 1'b1;
          end
        end
        DIV: begin
          r_p     <= w_div_next;
          r_count <= r_count + 1'b1;
          if (w_last) begin
            r_done <= 1'b1;
            if (r_b == '0) begin
              // Re-apply the dividend sign to return src_a exactly as given.
              r_lo <= DIV0_LO;
              r_hi <= r_neg_r ? -r_a : r_a;
            end else begin
              r_lo <= w_q_fix;
              r_hi <= w_r_fix;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy = (r_state != IDLE);
  assign bus.done = r_done;
  assign bus.hi   = r_hi;
  assign bus.lo   = r_lo;
endmodule

// File: tb/tb_mul_div_unit.sv
// -----------------------------------------------------------------------------
// tb_mul_div_unit -- directed bench for mul_div_unit with hand-computed results.
// Honours MD_FAST_MUL_EN for the expected multiply latency.
// -----------------------------------------------------------------------------
module tb_mul_div_unit;
  import md_pkg::*;

  localparam int DIV_LAT = 32;
`ifdef MD_FAST_MUL_EN
  localparam int MUL_LAT = 1;
`else
  localparam int MUL_LAT = 32;
`endif

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  mul_div_unit_if #(.WIDTH(32)) bus ();

  mul_div_unit dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Launch one operation and follow it to completion. Optionally pulse a start
  // plus hi_we at cycle inj_at (must be ignored while busy), and optionally
  // assert hi_we/lo_we together with start (start must win).
  task automatic do_op(input string tag, input md_op_e op, input logic [31:0] a,
                       input logic [31:0] b, input int lat, input logic [31:0] exp_hi,
                       input logic [31:0] exp_lo, input int inj_at, input logic we_with_start);
    int k;
    int busy_cyc;
    bus.op    = op;
    bus.src_a = a;
    bus.src_b = b;
    bus.start = 1'b1;
    bus.hi_we = we_with_start;
    bus.lo_we = we_with_start;
    bus.wdata = 32'h5555_5555;
    step();
    bus.start = 1'b0;
    bus.hi_we = 1'b0;
    bus.lo_we = 1'b0;
    bus.src_a = ~a;           // operands must already be captured
    bus.src_b = ~b;
    k        = 0;
    busy_cyc = 0;
    while (!bus.done && k < 200) begin
      if (bus.busy) busy_cyc++;
      if (k == inj_at) begin
        bus.start = 1'b1;
        bus.op    = MD_DIV;
        bus.hi_we = 1'b1;
        bus.wdata = 32'h0000_AAAA;
      end
      step();
      bus.start = 1'b0;
      bus.hi_we = 1'b0;
      k++;
    end
    check({tag, "_latency"}, 64'(k), 64'(lat));
    check({tag, "_busy_cycles"}, 64'(busy_cyc), 64'(lat));
    check({tag, "_busy_at_done"}, 64'(bus.busy), 64'd0);
    check({tag, "_hi"}, 64'(bus.hi), 64'(exp_hi));
    check({tag, "_lo"}, 64'(bus.lo), 64'(exp_lo));
    step();
    check({tag, "_done_single"}, 64'(bus.done), 64'd0);
  endtask

  initial begin
    int dones;
    rst       = 1'b1;
    bus.start = 1'b0;
    bus.op    = MD_MULT;
    bus.src_a = '0;
    bus.src_b = '0;
    bus.hi_we = 1'b0;
    bus.lo_we = 1'b0;
    bus.wdata = '0;
    step();
    step();
    check("reset_busy", 64'(bus.busy), 64'd0);
    check("reset_done", 64'(bus.done), 64'd0);
    check("reset_hi",   64'(bus.hi),   64'd0);
    check("reset_lo",   64'(bus.lo),   64'd0);
    rst = 1'b0;
    step();

    do_op("multu_max", MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, MUL_LAT, 32'hFFFF_FFFE, 32'h0000_0001, -1, 1'b0);
    do_op("mult_neg",  MD_MULT,  32'hFFFF_FFF9, 32'd6,         MUL_LAT, 32'hFFFF_FFFF, 32'hFFFF_FFD6, -1, 1'b0);
    do_op("mult_min",  MD_MULT,  32'h8000_0000, 32'h8000_0000, MUL_LAT, 32'h4000_0000, 32'h0000_0000, -1, 1'b0);
    do_op("mult_m1m1", MD_MULT,  32'hFFFF_FFFF, 32'hFFFF_FFFF, MUL_LAT, 32'h0000_0000, 32'h0000_0001, -1, 1'b0);
    do_op("mult_big",  MD_MULTU, 32'h0001_0000, 32'h0001_0000, MUL_LAT, 32'h0000_0001, 32'h0000_0000, -1, 1'b0);
    do_op("div_neg",   MD_DIV,   32'hFFFF_FFF9, 32'd2,         DIV_LAT, 32'hFFFF_FFFF, 32'hFFFF_FFFD, -1, 1'b0);
    do_op("div_negb",  MD_DIV,   32'd7,         32'hFFFF_FFFE, DIV_LAT, 32'h0000_0001, 32'hFFFF_FFFD, -1, 1'b0);
    do_op("divu_7",    MD_DIVU,  32'd100,       32'd7,         DIV_LAT, 32'd2,         32'd14,        -1, 1'b0);
    do_op("divu_zero", MD_DIVU,  32'd100,       32'd0,         DIV_LAT, 32'd100,       32'hFFFF_FFFF, -1, 1'b0);
    do_op("div_zero",  MD_DIV,   32'hFFFF_FFF9, 32'd0,         DIV_LAT, 32'hFFFF_FFF9, 32'hFFFF_FFFF, -1, 1'b0);
    do_op("div_ovf",   MD_DIV,   32'h8000_0000, 32'hFFFF_FFFF, DIV_LAT, 32'h0000_0000, 32'h8000_0000, -1, 1'b0);
    do_op("busy_ign",  MD_MULTU, 32'd3,         32'd5,         MUL_LAT, 32'h0000_0000, 32'd15,        10, 1'b0);
    do_op("start_win", MD_MULTU, 32'd2,         32'd3,         MUL_LAT, 32'h0000_0000, 32'd6,         -1, 1'b1);

    // Reset in the middle of a divide discards everything.
    bus.op    = MD_DIVU;
    bus.src_a = 32'd1000;
    bus.src_b = 32'd3;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    repeat (14) step();
    check("mid_busy", 64'(bus.busy), 64'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("abort_busy", 64'(bus.busy), 64'd0);
    check("abort_done", 64'(bus.done), 64'd0);
    check("abort_hi",   64'(bus.hi),   64'd0);
    check("abort_lo",   64'(bus.lo),   64'd0);
    dones = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (bus.done) dones++;
    end
    check("abort_no_done", 64'(dones), 64'd0);

    // MTHI and MTLO together in IDLE.
    bus.hi_we = 1'b1;
    bus.lo_we = 1'b1;
    bus.wdata = 32'h0000_1234;
    step();
    bus.hi_we = 1'b0;
    bus.lo_we = 1'b0;
    check("mt_hi", 64'(bus.hi), 64'h1234);
    check("mt_lo", 64'(bus.lo), 64'h1234);

    // MTLO alone leaves HI untouched.
    bus.lo_we = 1'b1;
    bus.wdata = 32'hCAFE_0001;
    step();
    bus.lo_we = 1'b0;
    check("mtlo_hi", 64'(bus.hi), 64'h1234);
    check("mtlo_lo", 64'(bus.lo), 64'hCAFE_0001);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
